nand_wdata_burst_feeder: RTL and testbench
==========================================

// Module: nand_wdata_burst_feeder
// PURPOSE
//  Upstream stage of the 32->16 decreasing width converter on the NAND program-data path.
//  Accepts a burst of iLength 32-bit words from the DMA source and buffers them in a small FIFO.
//  Releases them on a valid/ready interface that the width converter consumes directly.
//  Stops the source at exactly iLength words and pulses oDone once the last word has been handed off.
// PARAMETERS
//  DataWidth      32  width of each data word (source and destination sides)
//  FifoDepthLog2  2   log2 of FIFO depth (default 4 entries)
//  LengthWidth    16  width of the burst length (counted in words)
// PORTS
//  iClock      in   1                single clock; all logic is rising-edge
//  iReset      in   1                synchronous, active-high reset
//  iStart      in   1                burst start pulse; accepted only in Idle
//  iLength     in   LengthWidth      number of words in the burst; sampled with iStart
//  oBusy       out  1                high whenever state != Idle
//  oDone       out  1                one-cycle pulse at the end of a burst
//  iSrcValid   in   1                source word valid
//  iSrcData    in   DataWidth        source word
//  oSrcReady   out  1                feeder accepts a source word this cycle
//  oDstValid   out  1                head FIFO word is valid (drives converter iSrcDataValid)
//  oDstData    out  DataWidth        head FIFO word (drives converter iSrcData)
//  iDstReady   in   1                converter ready (from converter oConverterReady)
//  oFifoCount  out  FifoDepthLog2+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (synchronous, active-high) takes priority over everything, including mid-burst:
//   - state -> Idle; FIFO flushed (read ptr = write ptr = count = 0); both remain counters = 0.
//   - oBusy, oDone, oSrcReady and oDstValid are 0; oFifoCount is 0; oDstData is 0.
//  Handshakes: a transfer occurs on a rising edge where valid && ready; no other transfers.
//  States: Idle, Run, Done (encoding is free).
//   Idle: oSrcReady=0, oDstValid=0.
//    - iStart && iLength!=0 -> Run; load rInRemain = rOutRemain = iLength.
//    - iStart && iLength==0 -> Done.
//   Run:
//    - oSrcReady = (count < depth) && (rInRemain != 0), using the registered count only.
//      Full blocks a push even when a pop happens in the same cycle.
//    - oDstValid = (count != 0); oDstData = mem[read ptr] (combinational read of registered storage).
//    - Push: write at write ptr, write ptr+1, rInRemain-1.
//    - Pop: read ptr+1, rOutRemain-1.
//    - Push and pop in the same cycle: count unchanged.
//    - Pointers wrap modulo depth.
//    - No fall-through: a word pushed at edge E is visible on oDst from cycle E+1.
//    - Pop while rOutRemain==1 -> Done.
//   Done: oDone=1 for exactly this one cycle; oSrcReady=0, oDstValid=0; -> Idle.
//  iStart outside Idle is ignored; iLength is sampled only on an accepted start.
//  Source words offered beyond iLength are never accepted (oSrcReady stays 0).
//  oDstData must hold stable while oDstValid=1 and iDstReady=0.
//  Counters are LengthWidth bits wide; maximum burst is 2^LengthWidth-1 words.
// TESTING
//  1 Assert iReset 3 cycles -> oBusy=0, oDone=0, oSrcReady=0, oDstValid=0, oFifoCount=0.
//  2 iStart with iLength=3; src always valid with 0xA0000001..0xA0000003; iDstReady=1
//    -> outputs 0xA0000001..3 in order; first oDstValid one cycle after first push;
//       oDone pulses one cycle after the 3rd pop; then Idle.
//  3 iLength=6 with iDstReady=0 -> 4 pushes, oFifoCount=4, oSrcReady=0;
//    release iDstReady -> all 6 words delivered in order, oFifoCount back to 0, oDone once.
//  4 iLength=0 -> oDone pulses in the cycle after iStart; no src or dst transfer occurs.
//  5 iLength=2 with iSrcValid held high -> exactly 2 words accepted;
//    a second iStart during Run is ignored (no reload of the counters).
//  6 iReset asserted mid-burst with oFifoCount=3 -> next cycle oFifoCount=0, oBusy=0;
//    a new burst after reset completes normally.

Source files
------------

// File: rtl/nand_wdata_burst_feeder.sv
// Burst feeder ahead of the 32->16 width converter on the NAND program-data path.
// Accepts exactly iLength source words into a small FIFO and hands them off on a valid/ready port.
module nand_wdata_burst_feeder #(
    parameter int DataWidth     = 32,
    parameter int FifoDepthLog2 = 2,
    parameter int LengthWidth   = 16
) (
    input  logic                     iClock,
    input  logic                     iReset,
    input  logic                     iStart,
    input  logic [LengthWidth-1:0]   iLength,
    output logic                     oBusy,
    output logic                     oDone,
    input  logic                     iSrcValid,
    input  logic [DataWidth-1:0]     iSrcData,
    output logic                     oSrcReady,
    output logic                     oDstValid,
    output logic [DataWidth-1:0]     oDstData,
    input  logic                     iDstReady,
    output logic [FifoDepthLog2:0]   oFifoCount
);

    localparam int Depth = 1 << FifoDepthLog2;
    localparam logic [FifoDepthLog2:0] DepthCnt = (FifoDepthLog2+1)'(Depth);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_nxt;
    logic [DataWidth-1:0]     mem [Depth];
    logic [FifoDepthLog2-1:0] rd_ptr, wr_ptr;
    logic [FifoDepthLog2:0]   count;
    logic [LengthWidth-1:0]   in_remain, out_remain;
    logic                     push, pop;

    always_comb begin
        state_nxt = state;
        oSrcReady = 1'b0;
        oDstValid = 1'b0;
        oDone     = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) state_nxt = (iLength != '0) ? RUN : DONE;
            end
            RUN: begin
                // Registered count only: a full FIFO refuses a push even if a pop frees a slot this cycle.
                oSrcReady = (count < DepthCnt) && (in_remain != '0);
                oDstValid = (count != '0);
                if (oDstValid && iDstReady && out_remain == LengthWidth'(1)) state_nxt = DONE;
            end
            DONE: begin
                oDone     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign push       = oSrcReady && iSrcValid;
    assign pop        = oDstValid && iDstReady;
    assign oBusy      = (state != IDLE);
    assign oFifoCount = count;
    // Head word is forced to zero whenever nothing is offered, so reset leaves the port quiet.
    assign oDstData   = oDstValid ? mem[rd_ptr] : '0;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            in_remain  <= '0;
            out_remain <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && iStart) begin
                in_remain  <= iLength;
                out_remain <= iLength;
            end
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                in_remain <= in_remain - 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                out_remain <= out_remain - 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClock) begin
        if (push) mem[wr_ptr] <= iSrcData;
    end

endmodule

// File: tb/tb_nand_wdata_burst_feeder.sv
// Bench for nand_wdata_burst_feeder: table of bursts with a word scoreboard,
// plus hand-written reset sequences.
module tb_nand_wdata_burst_feeder;

    logic        clk = 1'b0;
    logic        iReset, iStart, iSrcValid, iDstReady;
    logic [15:0] iLength;
    logic [31:0] iSrcData;
    logic        oBusy, oDone, oSrcReady, oDstValid;
    logic [31:0] oDstData;
    logic [2:0]  oFifoCount;

    nand_wdata_burst_feeder dut (
        .iClock(clk), .iReset(iReset), .iStart(iStart), .iLength(iLength),
        .oBusy(oBusy), .oDone(oDone), .iSrcValid(iSrcValid), .iSrcData(iSrcData),
        .oSrcReady(oSrcReady), .oDstValid(oDstValid), .oDstData(oDstData),
        .iDstReady(iDstReady), .oFifoCount(oFifoCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [31:0] base;
        int          src_gap;   // percent of cycles the source idles
        int          dst_gap;   // percent of cycles the sink stalls
        int          stall;     // sink held off for this many cycles first
        bit          hold;      // source valid held high throughout
        bit          poke;      // issue a second iStart while running
    } vec_t;

    int total = 0, bad = 0;
    int cyc_ctr = 0;
    int src_cnt, dst_cnt, done_cnt = 0;
    int start_cyc, first_push, first_valid, last_pop, done_cyc;
    logic [31:0] exp_q[$];
    bit          held = 1'b0;
    logic [31:0] held_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    // Observations at the falling edge describe the transfers of the next rising edge.
    always @(negedge clk) begin
        if (!iReset) begin
            if (iStart && !oBusy) start_cyc = cyc_ctr;
            if (iSrcValid && oSrcReady) begin
                if (first_push < 0) first_push = cyc_ctr;
                src_cnt++;
            end
            if (oDstValid && first_valid < 0) first_valid = cyc_ctr;
            if (held && oDstValid) check("dst_hold", oDstData, held_data);
            if (oDstValid && iDstReady) begin
                if (exp_q.size() == 0) check("dst_extra", 32'd1, 32'd0);
                else check("dst_data", oDstData, exp_q.pop_front());
                dst_cnt++;
                last_pop = cyc_ctr;
            end
            held      = oDstValid && !iDstReady;
            held_data = oDstData;
            if (oDone) begin
                done_cnt++;
                done_cyc = cyc_ctr;
            end
        end
    end

    task automatic run_burst(input vec_t v, input string name);
        int cyc;
        int d0;
        int fill;
        src_cnt = 0; dst_cnt = 0; d0 = done_cnt;
        start_cyc = -1; first_push = -1; first_valid = -1; last_pop = -1; done_cyc = -1;
        fill = (v.len > 4) ? 4 : int'(v.len);
        for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.base + i);
        iStart = 1'b1; iLength = v.len;
        @(posedge clk); #1;
        iStart = 1'b0; iLength = 16'hFFFF;
        cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin
            if (v.stall > 0 && cyc == v.stall) begin
                check({name, "_stall_count"}, 32'(oFifoCount), 32'(fill));
                check({name, "_stall_srcready"}, 32'(oSrcReady), 32'd0);
                check({name, "_stall_pushed"}, src_cnt, fill);
            end
            iStart    = v.poke && cyc == 1;
            iLength   = 16'd9;
            iSrcValid = v.hold ? 1'b1 :
                        (src_cnt < int'(v.len) && $urandom_range(99) >= v.src_gap);
            iSrcData  = v.base + src_cnt;
            iDstReady = (cyc < v.stall) ? 1'b0 : ($urandom_range(99) >= v.dst_gap);
            @(posedge clk); #1;
            cyc++;
        end
        iStart = 1'b0; iSrcValid = 1'b0; iDstReady = 1'b0;
        check({name, "_timeout"}, 32'(cyc < 3000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_src_words"}, src_cnt, int'(v.len));
        check({name, "_dst_words"}, dst_cnt, int'(v.len));
        check({name, "_left_in_q"}, exp_q.size(), 0);
        check({name, "_idle"}, 32'(oBusy), 32'd0);
        if (v.len != 0) begin
            check({name, "_first_valid_lat"}, first_valid - first_push, 1);
            check({name, "_done_lat"}, done_cyc - last_pop, 1);
        end else begin
            check({name, "_zero_done_lat"}, done_cyc - start_cyc, 1);
        end
        exp_q.delete();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, 32'(oBusy), 32'd0);
        check({name, "_done"}, 32'(oDone), 32'd0);
        check({name, "_srcready"}, 32'(oSrcReady), 32'd0);
        check({name, "_dstvalid"}, 32'(oDstValid), 32'd0);
        check({name, "_count"}, 32'(oFifoCount), 32'd0);
        check({name, "_dstdata"}, oDstData, 32'd0);
    endtask

    vec_t vecs[8];
    vec_t tail;
    int   w;

    initial begin
        vecs[0] = '{16'd3,  32'hA000_0001, 0,  0,  0,  1'b0, 1'b0};
        vecs[1] = '{16'd6,  32'hB000_0000, 0,  0,  10, 1'b0, 1'b0};
        vecs[2] = '{16'd0,  32'hC000_0000, 0,  0,  0,  1'b0, 1'b0};
        vecs[3] = '{16'd2,  32'hD000_0000, 0,  0,  3,  1'b1, 1'b1};
        vecs[4] = '{16'd20, 32'h1000_0000, 30, 30, 0,  1'b0, 1'b0};
        vecs[5] = '{16'd9,  32'h2000_0000, 60, 10, 0,  1'b0, 1'b0};
        vecs[6] = '{16'd1,  32'h3000_0000, 0,  50, 0,  1'b0, 1'b0};
        vecs[7] = '{16'd17, 32'h4000_0000, 0,  0,  0,  1'b0, 1'b0};
        tail    = '{16'd5,  32'h6000_0000, 20, 20, 0,  1'b0, 1'b0};

        iReset = 1'b1; iStart = 1'b0; iLength = '0;
        iSrcValid = 1'b0; iSrcData = '0; iDstReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        iReset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a burst with three words buffered.
        src_cnt = 0;
        iStart = 1'b1; iLength = 16'd8;
        @(posedge clk); #1;
        iStart = 1'b0;
        w = 0;
        while (oFifoCount != 3'd3 && w < 20) begin
            iSrcValid = 1'b1; iSrcData = 32'h5000_0000 + src_cnt; iDstReady = 1'b0;
            @(posedge clk); #1;
            w++;
        end
        check("midreset_fill", 32'(oFifoCount), 32'd3);
        iReset = 1'b1; iSrcValid = 1'b0;
        @(posedge clk); #1;
        check_quiet("midreset");
        iReset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        run_burst(tail, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
